// File: rtl/multi_free_list_if.sv
// Rename/retire port bundle for the multi-way physical-register free list.
// master = rename/retire side, slave = free list.
interface multi_free_list_if #(
   parameter int NUM_PHYS_REG = 64,
   parameter int NUM_ARCH_REG = 32,
   parameter int WAYS         = 2,
   parameter int NUM_CKPT     = 4
);
   localparam int PW  = $clog2(NUM_PHYS_REG);
   localparam int D   = NUM_PHYS_REG - NUM_ARCH_REG;
   localparam int PTW = $clog2(D) + 1;
   localparam int AW  = $clog2(WAYS + 1);
   localparam int CW  = $clog2(NUM_CKPT);

   logic [AW-1:0]            alloc_num;
   logic [WAYS-1:0][PW-1:0]  alloc_tag;
   logic                     alloc_ok;
   logic [AW-1:0]            free_num;
   logic [WAYS-1:0][PW-1:0]  free_tag;
   logic                     ckpt_save;
   logic [CW-1:0]            ckpt_save_id;
   logic                     ckpt_restore;
   logic [CW-1:0]            ckpt_restore_id;
   logic [PTW-1:0]           num_free;
   logic                     fl_error;

   modport master (
      output alloc_num, free_num, free_tag,
      output ckpt_save, ckpt_save_id,
      output ckpt_restore, ckpt_restore_id,
      input  alloc_tag, alloc_ok, num_free, fl_error
   );

   modport slave (
      input  alloc_num, free_num, free_tag,
      input  ckpt_save, ckpt_save_id,
      input  ckpt_restore, ckpt_restore_id,
      output alloc_tag, alloc_ok, num_free, fl_error
   );
endinterface

// File: rtl/multi_free_list.sv
// N-way circular physical-register free list with head-only checkpoints.
// FL_DEBUG_EN adds dbg_head/dbg_tail/dbg_list ports and sim assertions.
module multi_free_list #(
   parameter int NUM_PHYS_REG = 64,
   parameter int NUM_ARCH_REG = 32,
   parameter int WAYS         = 2,
   parameter int NUM_CKPT     = 4,
   localparam int PW  = $clog2(NUM_PHYS_REG),
   localparam int D   = NUM_PHYS_REG - NUM_ARCH_REG,
   localparam int IW  = $clog2(D),
   localparam int PTW = IW + 1
) (
   input logic              clock,
   input logic              reset,
   multi_free_list_if.slave fl
`ifdef FL_DEBUG_EN
   ,
   output logic [PTW-1:0]        dbg_head,
   output logic [PTW-1:0]        dbg_tail,
   output logic [D-1:0][PW-1:0]  dbg_list
`endif
);
   localparam int AW = $clog2(WAYS + 1);

   logic [PW-1:0]  list [D];
   logic [PTW-1:0] ckpt [NUM_CKPT];
   logic [PTW-1:0] head, tail;
   logic [PTW-1:0] head_nxt, tail_nxt;
   logic [PTW-1:0] head_add, save_val;
   logic [PTW-1:0] num_free;
   logic [IW-1:0]  widx [WAYS];
   logic [WAYS-1:0] we;
   logic alloc_bad, alloc_go;
   logic free_bad, free_go;
   logic save_go, err;

   // Index arithmetic uses an explicit wrap compare so D need not be 2^n.
   function automatic logic [IW-1:0] idx_add(
      input logic [IW-1:0] idx,
      input int            n
   );
      int s;
      s = int'(idx) + n;
      if (s >= D) s = s - D;
      return IW'(s);
   endfunction

   function automatic logic [PTW-1:0] ptr_add(
      input logic [PTW-1:0] p,
      input int             n
   );
      logic wrap;
      wrap = (int'(p[IW-1:0]) + n) >= D;
      return {p[IW] ^ wrap, idx_add(p[IW-1:0], n)};
   endfunction

   always_comb begin
      if (head[IW] == tail[IW])
         num_free = PTW'(tail[IW-1:0]) - PTW'(head[IW-1:0]);
      else
         num_free = PTW'(D) - PTW'(head[IW-1:0])
                  + PTW'(tail[IW-1:0]);
   end

   assign fl.num_free = num_free;
   assign fl.alloc_ok = PTW'(fl.alloc_num) <= num_free;
   assign fl.fl_error = err;

   always_comb begin
      for (int i = 0; i < WAYS; i++)
         fl.alloc_tag[i] = list[idx_add(head[IW-1:0], i)];
   end

   // A restore cancels this cycle's allocation and save entirely.
   always_comb begin
      alloc_bad = !fl.ckpt_restore &&
                  (PTW'(fl.alloc_num) > num_free ||
                   fl.alloc_num > AW'(WAYS));
      alloc_go  = !fl.ckpt_restore && !alloc_bad &&
                  fl.alloc_num != '0;
      head_add  = ptr_add(head, int'(fl.alloc_num));
      save_val  = alloc_go ? head_add : head;
      save_go   = fl.ckpt_save && !fl.ckpt_restore;
      if (fl.ckpt_restore)
         head_nxt = ckpt[fl.ckpt_restore_id];
      else if (alloc_go)
         head_nxt = head_add;
      else
         head_nxt = head;
   end

   always_comb begin
      free_bad = ({1'b0, num_free} + (PTW+1)'(fl.free_num))
                 > (PTW+1)'(D) ||
                 fl.free_num > AW'(WAYS);
      free_go  = !free_bad && fl.free_num != '0;
      tail_nxt = free_go ? ptr_add(tail, int'(fl.free_num)) : tail;
      for (int i = 0; i < WAYS; i++) begin
         widx[i] = idx_add(tail[IW-1:0], i);
         we[i]   = free_go && (AW'(i) < fl.free_num);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head <= '0;
         tail <= {1'b1, IW'(0)};
         err  <= 1'b0;
         for (int i = 0; i < D; i++)
            list[i] <= PW'(NUM_ARCH_REG + i);
         for (int c = 0; c < NUM_CKPT; c++)
            ckpt[c] <= '0;
      end else begin
         head <= head_nxt;
         tail <= tail_nxt;
         err  <= err | alloc_bad | free_bad;
         for (int i = 0; i < WAYS; i++)
            if (we[i]) list[widx[i]] <= fl.free_tag[i];
         if (save_go)
            ckpt[fl.ckpt_save_id] <= save_val;
      end
   end

`ifdef FL_DEBUG_EN
   assign dbg_head = head;
   assign dbg_tail = tail;

   always_comb begin
      for (int i = 0; i < D; i++)
         dbg_list[i] = list[i];
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         assert (!err);
         for (int j = 0; j < D; j++)
            for (int k = j + 1; k < D; k++)
               if (PTW'(k) < num_free)
                  assert (list[idx_add(head[IW-1:0], j)] !=
                          list[idx_add(head[IW-1:0], k)]);
         for (int i = 0; i < WAYS; i++)
            for (int j = 0; j < D; j++)
               if (we[i] && PTW'(j) < num_free)
                  assert (fl.free_tag[i] !=
                          list[idx_add(head[IW-1:0], j)]);
      end
   end
`endif

endmodule

// File: tb/tb_multi_free_list.sv
// Free-list bench: directed scenarios plus random traffic against a
// sequence-number model (tag history indexed by absolute head/tail counts).
module tb_multi_free_list;
   localparam int D    = 32;
   localparam int WAYS = 2;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   multi_free_list_if fl ();

   multi_free_list dut (
      .clock (clock),
      .reset (reset),
      .fl    (fl)
   );

   int checks = 0;
   int errors = 0;

   // hist[k] = k-th tag ever placed in the list; live window is [h, t).
   int hist [8192];
   int h, t;
   int ck [4];
   int merr;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < D; k++) hist[k] = 32 + k;
      h = 0;
      t = D;
      merr = 0;
      for (int c = 0; c < 4; c++) ck[c] = 0;
   endtask

   task automatic compare(input string tag);
      chk({tag, ".num_free"}, int'(fl.num_free), t - h);
      chk({tag, ".fl_error"}, int'(fl.fl_error), merr);
      for (int i = 0; i < WAYS; i++)
         if (i < t - h)
            chk($sformatf("%s.tag%0d", tag, i),
                int'(fl.alloc_tag[i]), hist[h + i]);
   endtask

   task automatic idle_inputs();
      fl.alloc_num = '0;
      fl.free_num = '0;
      fl.free_tag = '0;
      fl.ckpt_save = 1'b0;
      fl.ckpt_save_id = '0;
      fl.ckpt_restore = 1'b0;
      fl.ckpt_restore_id = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(posedge clock);
      #1;
      reset = 1'b0;
      model_reset();
      compare("reset");
   endtask

   task automatic step(input string tag, input int an, input int fn,
                       input int tg0, input int tg1,
                       input bit sv, input int svid,
                       input bit rs, input int rsid);
      int nf, hn;
      fl.alloc_num = 2'(an);
      fl.free_num = 2'(fn);
      fl.free_tag[0] = 6'(tg0);
      fl.free_tag[1] = 6'(tg1);
      fl.ckpt_save = sv;
      fl.ckpt_save_id = 2'(svid);
      fl.ckpt_restore = rs;
      fl.ckpt_restore_id = 2'(rsid);
      #1;
      chk({tag, ".alloc_ok"}, int'(fl.alloc_ok), int'(an <= t - h));
      nf = t - h;
      hn = h;
      if (rs) hn = ck[rsid];
      else begin
         if (an > nf) merr = 1;
         else hn = h + an;
         if (sv) ck[svid] = hn;
      end
      if (nf + fn > D) merr = 1;
      else begin
         if (fn > 0) hist[t] = tg0;
         if (fn > 1) hist[t + 1] = tg1;
         t = t + fn;
      end
      h = hn;
      @(posedge clock);
      #1;
      idle_inputs();
      compare(tag);
   endtask

   initial begin
      int an, fn, svid, rsid, tn;
      bit sv, rs;
      reset = 1'b1;
      idle_inputs();
      @(posedge clock);
      #1;
      do_reset();
      chk("reset.tag0_const", int'(fl.alloc_tag[0]), 32);
      chk("reset.tag1_const", int'(fl.alloc_tag[1]), 33);
      chk("reset.nf_const", int'(fl.num_free), 32);

      // drain
      for (int k = 0; k < 16; k++) begin
         chk("drain.tag0", int'(fl.alloc_tag[0]), 32 + 2 * k);
         chk("drain.tag1", int'(fl.alloc_tag[1]), 33 + 2 * k);
         step("drain", 2, 0, 0, 0, 0, 0, 0, 0);
      end
      chk("empty.nf", int'(fl.num_free), 0);
      fl.alloc_num = 2'd2;
      #1;
      chk("empty.ok", int'(fl.alloc_ok), 0);
      step("underflow", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("underflow.err", int'(fl.fl_error), 1);

      // simultaneous alloc and free
      do_reset();
      step("a30", 2, 0, 0, 0, 0, 0, 0, 0);
      step("af", 2, 2, 5, 7, 0, 0, 0, 0);
      chk("af.nf", int'(fl.num_free), 30);
      for (int k = 0; k < 14; k++)
         step("af.drain", 2, 0, 0, 0, 0, 0, 0, 0);
      chk("af.tag5", int'(fl.alloc_tag[0]), 5);
      chk("af.tag7", int'(fl.alloc_tag[1]), 7);

      // checkpoint save / restore
      do_reset();
      step("save", 2, 0, 0, 0, 1, 1, 0, 0);
      step("more0", 2, 0, 0, 0, 0, 0, 0, 0);
      step("more1", 2, 0, 0, 0, 0, 0, 0, 0);
      step("restore", 2, 1, 9, 0, 1, 2, 1, 1);
      chk("restore.tag0", int'(fl.alloc_tag[0]), 34);
      chk("restore.nf", int'(fl.num_free), 31);

      // wrap with steady alloc/free
      do_reset();
      step("w.pre", 2, 0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 40; k++) begin
         step("wrap", 2, 2, $urandom_range(0, 63),
              $urandom_range(0, 63), 0, 0, 0, 0);
         chk("wrap.nf", int'(fl.num_free), 30);
      end
      chk("wrap.err", int'(fl.fl_error), 0);

      // overflow
      do_reset();
      step("ovf", 0, 1, 3, 0, 0, 0, 0, 0);
      chk("ovf.err", int'(fl.fl_error), 1);
      chk("ovf.nf", int'(fl.num_free), 32);
      step("ovf.hold0", 0, 0, 0, 0, 0, 0, 0, 0);
      step("ovf.hold1", 1, 0, 0, 0, 0, 0, 0, 0);
      chk("ovf.sticky", int'(fl.fl_error), 1);
      do_reset();

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         an = $urandom_range(0, 2);
         fn = $urandom_range(0, 2);
         sv = ($urandom_range(0, 3) == 0);
         svid = $urandom_range(0, 3);
         rs = ($urandom_range(0, 9) == 0);
         rsid = $urandom_range(0, 3);
         tn = (t - h + fn <= D) ? t + fn : t;
         if (tn - ck[rsid] > D || tn - ck[rsid] < 0) rs = 0;
         step("rand", an, fn, $urandom_range(0, 63),
              $urandom_range(0, 63), sv, svid, rs, rsid);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
